// File: rtl/u712_chipram_arbiter.sv
// u712_chipram_arbiter: grants the chip RAM sequencer to DMA, refresh or CPU, enforces a precharge gap and tracks owed refreshes.
// Build option U712_REF_POSTPONE_EN: CPU may defer refresh until REF_URGENT_LVL refreshes are owed.
module u712_chipram_arbiter #(
    parameter int RP_GAP         = 2,
    parameter int BUSY_MAX       = 31,
    parameter int REF_URGENT_LVL = 4
) (
    input  logic       CLK80,
    input  logic       RESET,
    input  logic       DMA_REQ,
    input  logic       DMA_PEND,
    input  logic       CPU_REQ,
    input  logic       CPU_BURST,
    input  logic       REF_TICK,
    input  logic       SEQ_DONE,
    output logic       START,
    output logic       GNT_DMA,
    output logic       GNT_CPU,
    output logic       GNT_REF,
    output logic       GNT_BURST,
    output logic [2:0] REF_PEND,
    output logic       REF_OVF,
    output logic       TIMEOUT
);
    typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DMA, OWN_CPU, OWN_REF} own_t;

`ifdef U712_REF_POSTPONE_EN
    localparam bit POSTPONE = 1'b1;
`else
    localparam bit POSTPONE = 1'b0;
`endif
    localparam logic [2:0] GAP_LAST = 3'(RP_GAP - 1);
    localparam logic [5:0] WD_LAST  = 6'(BUSY_MAX - 1);

    state_t     r_state;
    own_t       r_own;
    logic       r_burst_req;
    logic [2:0] r_gap_cnt;
    logic [5:0] r_wd_cnt;
    logic [2:0] r_ref_pend;
    logic       r_ref_ovf;
    logic       r_start;
    logic       r_gnt_dma;
    logic       r_gnt_cpu;
    logic       r_gnt_ref;
    logic       r_gnt_burst;
    logic       r_timeout;

    logic       w_ref_any;
    logic       w_ref_hi;
    logic       w_cpu_ok;
    logic       w_ref_dec;
    own_t       w_win;

    assign w_ref_any = r_ref_pend != 3'd0;
    // Without postponement any owed refresh beats the CPU
    assign w_ref_hi  = POSTPONE ? (r_ref_pend >= 3'(REF_URGENT_LVL)) : w_ref_any;
    assign w_cpu_ok  = CPU_REQ && !DMA_PEND;
    assign w_win     = DMA_REQ  ? OWN_DMA :
                       w_ref_hi ? OWN_REF :
                       w_cpu_ok ? OWN_CPU :
                       w_ref_any ? OWN_REF : OWN_NONE;
    assign w_ref_dec = (r_state == GRANT) && (r_own == OWN_REF) && w_ref_any;

    always_ff @(posedge CLK80 or posedge RESET) begin
        if (RESET) begin
            r_ref_pend <= 3'd0;
            r_ref_ovf  <= 1'b0;
        end else if (REF_TICK && !w_ref_dec) begin
            if (r_ref_pend == 3'd7)
                r_ref_ovf <= 1'b1;
            else
                r_ref_pend <= r_ref_pend + 3'd1;
        end else if (!REF_TICK && w_ref_dec) begin
            r_ref_pend <= r_ref_pend - 3'd1;
        end
    end

    // The last GAP cycle doubles as the IDLE evaluation so the next START lands RP_GAP+1 cycles after GNT drops
    always_ff @(posedge CLK80 or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_own       <= OWN_NONE;
            r_burst_req <= 1'b0;
            r_gap_cnt   <= 3'd0;
            r_wd_cnt    <= 6'd0;
            r_start     <= 1'b0;
            r_gnt_dma   <= 1'b0;
            r_gnt_cpu   <= 1'b0;
            r_gnt_ref   <= 1'b0;
            r_gnt_burst <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE, GAP: begin
                    if (r_state == GAP && r_gap_cnt != GAP_LAST) begin
                        r_gap_cnt <= r_gap_cnt + 3'd1;
                    end else begin
                        r_gap_cnt   <= 3'd0;
                        r_own       <= w_win;
                        r_burst_req <= CPU_BURST;
                        r_state     <= (w_win == OWN_NONE) ? IDLE : GRANT;
                    end
                end
                GRANT: begin
                    r_start     <= 1'b1;
                    r_gnt_dma   <= r_own == OWN_DMA;
                    r_gnt_cpu   <= r_own == OWN_CPU;
                    r_gnt_ref   <= r_own == OWN_REF;
                    r_gnt_burst <= (r_own == OWN_CPU) && r_burst_req;
                    r_wd_cnt    <= 6'd0;
                    r_state     <= BUSY;
                end
                BUSY: begin
                    if (SEQ_DONE || r_wd_cnt == WD_LAST) begin
                        r_gnt_dma   <= 1'b0;
                        r_gnt_cpu   <= 1'b0;
                        r_gnt_ref   <= 1'b0;
                        r_gnt_burst <= 1'b0;
                        r_timeout   <= !SEQ_DONE;
                        r_gap_cnt   <= 3'd0;
                        r_state     <= GAP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 6'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign START     = r_start;
    assign GNT_DMA   = r_gnt_dma;
    assign GNT_CPU   = r_gnt_cpu;
    assign GNT_REF   = r_gnt_ref;
    assign GNT_BURST = r_gnt_burst;
    assign REF_PEND  = r_ref_pend;
    assign REF_OVF   = r_ref_ovf;
    assign TIMEOUT   = r_timeout;
endmodule

// File: doc/u712_chipram_arbiter.md
# u712_chipram_arbiter

Chip RAM access arbiter for U712. Accepts access requests from Agnus DMA, the SDRAM refresh timer and the CPU. Grants the single SDRAM sequencer to exactly one owner at a time, and enforces a precharge turnaround gap between accesses. Tracks owed refreshes so CPU traffic can defer refresh without ever losing one.

## Interface
Parameters:
- RP_GAP, 2: idle cycles enforced after SEQ_DONE before the next grant (1..7).
- BUSY_MAX, 31: maximum BUSY cycles before watchdog abort (1..63).
- REF_URGENT_LVL, 4: owed-refresh count at which refresh outranks CPU (1..7).

Ports:
- CLK80, in, 1: 80 MHz clock, rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- DMA_REQ, in, 1: Agnus DMA request level; held until granted.
- DMA_PEND, in, 1: Agnus RAS seen, DMA imminent; blocks new CPU grants.
- CPU_REQ, in, 1: CPU chip RAM request level; held until granted.
- CPU_BURST, in, 1: CPU request is a line burst; sampled with grant.
- REF_TICK, in, 1: one-cycle pulse, one refresh owed.
- SEQ_DONE, in, 1: sequencer finished current access (one-cycle pulse).
- START, out, 1: one-cycle pulse, sequencer begins access.
- GNT_DMA, GNT_CPU, GNT_REF, out, 1 each: owner flags, one-hot or all zero, held from START through SEQ_DONE.
- GNT_BURST, out, 1: captured CPU_BURST for the current CPU grant, else 0.
- REF_PEND, out, 3: owed refresh count.
- REF_OVF, out, 1: sticky, set when a tick arrives with REF_PEND=7.
- TIMEOUT, out, 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, GRANT, BUSY, GAP.
- IDLE: evaluates requests in priority order:
  1. DMA_REQ.
  2. Refresh, if REF_PEND >= REF_URGENT_LVL.
  3. CPU_REQ with DMA_PEND=0.
  4. Refresh, if REF_PEND > 0.
- If a request wins, go to GRANT; otherwise stay in IDLE.
- GRANT (1 cycle):
  - START=1 and the winner's GNT flag set.
  - GNT_BURST = CPU_BURST if the winner is CPU.
  - Go to BUSY.
- BUSY:
  - Grant flags held.
  - Watchdog counter increments each cycle.
  - On SEQ_DONE=1: clear flags, go to GAP.
  - On counter reaching BUSY_MAX: clear flags, pulse TIMEOUT, go to GAP.
- GAP: counts RP_GAP cycles, then IDLE. No grants are issued in GAP.
- REF_PEND:
  - +1 on REF_TICK.
  - −1 when GRANT issues GNT_REF.
  - Both in the same cycle: unchanged.
  - Tick at 7: stays 7 and REF_OVF is set.
  - Never decrements below 0.
- Requests arriving during GRANT/BUSY/GAP are not lost; they are level-held by the sources and evaluated in the next IDLE.
- DMA_PEND rising during BUSY has no effect on the current grant.

## Timing
- Reset values: state IDLE, START=0, all GNT=0, GNT_BURST=0, REF_PEND=0, REF_OVF=0, TIMEOUT=0, counters 0.
- All outputs are registered; no combinational input-to-output paths.
- Request sampled high in IDLE at edge N: START and GNT high after edge N+1.
- SEQ_DONE at edge M: GNT low after M+1. Earliest next START is after M+2+RP_GAP.
- SEQ_DONE and watchdog expiry in the same cycle: SEQ_DONE wins, no TIMEOUT.
- SEQ_DONE outside BUSY is ignored.
- RESET asserted mid-access: all outputs clear immediately. The sequencer must treat the loss of GNT as an abort.

## Configuration
- U712_REF_POSTPONE_EN defined:
  - Refresh deferral enabled, with priority as listed under Operation.
- U712_REF_POSTPONE_EN undefined:
  - Any REF_PEND > 0 outranks CPU. The effective priority becomes DMA, refresh, CPU.
  - REF_URGENT_LVL is ignored.
  - REF_PEND and REF_OVF behave identically in both configurations.

## Test plan
- Reset, then CPU_REQ=1 with CPU_BURST=1 → START and GNT_CPU after 2 edges, GNT_BURST=1. SEQ_DONE 6 cycles later → GNT_CPU low, no START for RP_GAP+1 cycles.
- DMA_REQ and CPU_REQ rise in the same cycle in IDLE → GNT_DMA first. CPU is granted at the first IDLE after the DMA access's gap.
- CPU_REQ held with DMA_PEND=1 → no grant. DMA_PEND falls → CPU granted 2 edges later.
- 4 REF_TICKs while CPU_REQ is continuously re-asserted (macro defined) → CPU is served until REF_PEND=4, then GNT_REF; REF_PEND steps back to 3. With the macro undefined, GNT_REF precedes CPU after the first tick.
- 8 REF_TICKs with no SEQ_DONE completions and grants blocked by a DMA_REQ hog → REF_PEND saturates at 7 and REF_OVF=1. A tick coincident with a GNT_REF issue leaves REF_PEND unchanged.
- Grant issued, SEQ_DONE withheld → TIMEOUT pulse after BUSY_MAX BUSY cycles, grant dropped. RESET asserted mid-BUSY → all outputs 0 immediately.
